spi_slave_fsm_burst: RTL and testbench
======================================

Name: spi_slave_fsm_burst

Overview:
- Parametrised successor to the SPI slave control FSM. Runs on the system clock and consumes the conditioned chip-select and SCLK rising-edge strobe from the input conditioners.
- Sequences address capture, read load/shift and write commit, with generic address/data widths, configurable memory read latency, and optional burst mode with address auto-increment.
- Drives the address latch, shift register, MISO tri-state buffer and data memory write-enable.

Parameters:
- ADDR_W, 7, address bits in the header; header length is ADDR_W+1 (last bit is R/W, 1=read).
- DATA_W, 8, data word length in SCLK edges.
- MEM_LAT, 1, system clocks between ad_we and valid memory read data (≥1).
- BURST_EN, 1, 1 allows consecutive words while CS stays low; 0 gives a single word per frame.

Ports:
- s_clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- CS  in  1  conditioned chip select, active low.
- sclk_pos  in  1  one-s_clk strobe per SCLK rising edge.
- read_write  in  1  shift register LSB (R/W bit), sampled in GOT_ADDR.
- miso_buff  out  1  MISO tri-state enable.
- ad_we  out  1  address latch write enable.
- sr_we  out  1  shift register parallel-load enable.
- dm_we  out  1  data memory write enable.
- addr_inc  out  1  address latch increment pulse (burst).
- frame_err  out  1  one-cycle pulse when CS rises mid-word.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, bit counter 0, rw flag 0. Async assert, sync deassert handled upstream.
- Outputs are Moore, decoded from registered state. frame_err is a registered pulse.
- Bit counter increments on sclk_pos inside shift states and clears on every state change. Width is clog2(max(ADDR_W+1, DATA_W)+1).
- States and transitions:
  - IDLE: CS=0 → GET_ADDR.
  - GET_ADDR: after ADDR_W+1 sclk_pos strobes → GOT_ADDR.
  - GOT_ADDR (1 clk, ad_we=1): latch rw from read_write. rw=1 → READ_WAIT, else → WRITE_SHIFT.
  - READ_WAIT: stays MEM_LAT clocks → READ_LOAD.
  - READ_LOAD (1 clk, sr_we=1) → READ_SHIFT.
  - READ_SHIFT (miso_buff=1): after DATA_W strobes, BURST_EN=1 → RD_NEXT, else → DONE.
  - RD_NEXT (1 clk, addr_inc=1, miso_buff=1) → READ_WAIT.
  - WRITE_SHIFT: after DATA_W strobes → WRITE_COMMIT.
  - WRITE_COMMIT (1 clk, dm_we=1): BURST_EN=1 → WR_NEXT, else → DONE.
  - WR_NEXT (1 clk, addr_inc=1) → WRITE_SHIFT.
  - DONE: all enables 0; waits for CS=1.
- CS=1 is sampled every clock and has priority over all transitions, including a same-cycle sclk_pos. Next state is IDLE, and all enables are 0 the following clock.
- frame_err=1 for one clock if CS rises in GET_ADDR, READ_SHIFT or WRITE_SHIFT with counter ≠ 0.
  - Also if CS rises in WRITE_SHIFT with counter = 0 after at least one strobe in that word (i.e. never).
  - Partial write words never produce dm_we.
- CS rising exactly after the final strobe (in COMMIT/NEXT/DONE/LOAD/WAIT): no frame_err. A WRITE_COMMIT already entered completes its dm_we.
- Burst address wrap is the address latch's concern; the FSM only pulses addr_inc.
- Reset mid-operation: immediate return to IDLE, outputs 0, no frame_err.

Decomposition:
- Shared package/header spi_fsm_pkg: state encodings (11 states, 4-bit), R/W bit polarity constant, counter-width function.
- One sub-module, spi_bit_counter: parametrised width, clear and enable inputs, and terminal-count compare against a runtime limit (ADDR_W+1 or DATA_W).

Test Plan:
- Defaults, CS low, header 0x55 with R/W=0, 8 data strobes, CS high:
  - ad_we one clk after 8th strobe.
  - dm_we one clk after 16th strobe.
  - addr_inc once, then CS high → IDLE; frame_err=0.
- Read, MEM_LAT=1, header R/W=1:
  - ad_we, then 1 clk wait, then sr_we one clk.
  - miso_buff high through 8 strobes.
  - With BURST_EN=0: DONE, miso_buff=0.
- Burst read, 3 words, BURST_EN=1:
  - exactly 3 sr_we and 3 addr_inc pulses.
  - miso_buff continuously high from first READ_SHIFT until CS high.
- CS high after 4 of 8 write strobes:
  - frame_err pulses once, no dm_we, IDLE the next clock.
- reset_n low mid-READ_SHIFT:
  - all outputs 0 asynchronously.
  - After release with CS low, FSM restarts at GET_ADDR only after CS high→low.
- Params ADDR_W=15, DATA_W=16, MEM_LAT=3, write frame:
  - ad_we after 16th strobe, dm_we after 32nd strobe.
- Params ADDR_W=15, DATA_W=16, MEM_LAT=3, read frame:
  - 3-clk gap between ad_we and sr_we.

Source files
------------

// File: rtl/spi_fsm_pkg.sv
// Shared definitions for the SPI slave control FSM: state encoding,
// R/W bit polarity and the bit-counter width helper.
package spi_fsm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_GET_ADDR     = 4'd1,
        ST_GOT_ADDR     = 4'd2,
        ST_READ_WAIT    = 4'd3,
        ST_READ_LOAD    = 4'd4,
        ST_READ_SHIFT   = 4'd5,
        ST_RD_NEXT      = 4'd6,
        ST_WRITE_SHIFT  = 4'd7,
        ST_WRITE_COMMIT = 4'd8,
        ST_WR_NEXT      = 4'd9,
        ST_DONE         = 4'd10
    } spi_state_e;

    // Value of the final header bit that marks a read command.
    localparam logic RW_READ = 1'b1;

    // Bits needed to count up to the longer of header and data word.
    function automatic int cnt_width(input int addr_w, input int data_w);
        int longest;
        longest = ((addr_w + 1) > data_w) ? (addr_w + 1) : data_w;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// SCLK strobe counter with synchronous clear and a terminal-count flag
// that fires on the last strobe of a runtime-selected length.
module spi_bit_counter #(
    parameter int W = 4
) (
    input  logic         s_clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear takes precedence so a state change always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge s_clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_last = (count_q == (limit - W'(1)));

endmodule

// File: rtl/spi_slave_fsm_burst.sv
// SPI slave control FSM: header capture, read load/shift with memory
// latency, write commit, and optional burst with address auto-increment.
module spi_slave_fsm_burst
    import spi_fsm_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int MEM_LAT  = 1,
    parameter int BURST_EN = 1
) (
    input  logic s_clk,
    input  logic reset_n,
    input  logic CS,
    input  logic sclk_pos,
    input  logic read_write,
    output logic miso_buff,
    output logic ad_we,
    output logic sr_we,
    output logic dm_we,
    output logic addr_inc,
    output logic frame_err,
    output logic busy
);

    localparam int CW = cnt_width(ADDR_W, DATA_W);
    localparam logic [CW-1:0] HDR_LEN  = CW'(ADDR_W + 1);
    localparam logic [CW-1:0] WORD_LEN = CW'(DATA_W);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);

    spi_state_e state_q;
    spi_state_e state_d;
    logic       rw_q;
    logic       rw_d;
    logic       rd_cont_q;
    logic       rd_cont_d;
    logic       armed_q;
    logic       armed_d;
    logic       frame_err_q;
    logic       frame_err_d;
    logic [LW-1:0] lat_q;
    logic [LW-1:0] lat_d;

    logic [CW-1:0] bit_count;
    logic          bit_last;
    logic [CW-1:0] cnt_limit;
    logic          cnt_clr;
    logic          cnt_en;
    logic          in_shift;
    logic          word_done;

    assign in_shift  = (state_q == ST_GET_ADDR) || (state_q == ST_READ_SHIFT) ||
                       (state_q == ST_WRITE_SHIFT);
    assign cnt_limit = (state_q == ST_GET_ADDR) ? HDR_LEN : WORD_LEN;
    assign cnt_en    = sclk_pos && in_shift;
    assign cnt_clr   = (state_d != state_q);
    assign word_done = sclk_pos && bit_last;

    spi_bit_counter #(
        .W(CW)
    ) u_bit_counter (
        .s_clk   (s_clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (cnt_limit),
        .count   (bit_count),
        .at_last (bit_last)
    );

    // Next-state logic; a deasserted chip select overrides every transition.
    always_comb begin
        state_d = state_q;
        if (CS) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:         if (armed_q) state_d = ST_GET_ADDR;
                ST_GET_ADDR:     if (word_done) state_d = ST_GOT_ADDR;
                ST_GOT_ADDR:     state_d = (read_write == RW_READ) ? ST_READ_WAIT : ST_WRITE_SHIFT;
                ST_READ_WAIT:    if (lat_q == LAT_LAST) state_d = ST_READ_LOAD;
                ST_READ_LOAD:    state_d = ST_READ_SHIFT;
                ST_READ_SHIFT:   if (word_done) state_d = (BURST_EN != 0) ? ST_RD_NEXT : ST_DONE;
                ST_RD_NEXT:      state_d = ST_READ_WAIT;
                ST_WRITE_SHIFT:  if (word_done) state_d = ST_WRITE_COMMIT;
                ST_WRITE_COMMIT: state_d = (BURST_EN != 0) ? ST_WR_NEXT : ST_DONE;
                ST_WR_NEXT:      state_d = ST_WRITE_SHIFT;
                ST_DONE:         state_d = ST_DONE;
                default:         state_d = ST_IDLE;
            endcase
        end
    end

    // Auxiliary flags: R/W capture, burst MISO hold, re-arm after reset, latency count, framing error.
    always_comb begin
        rw_d        = (state_q == ST_GOT_ADDR) ? read_write : rw_q;
        armed_d     = armed_q || CS;
        lat_d       = (state_q == ST_READ_WAIT) ? (lat_q + LW'(1)) : '0;
        frame_err_d = CS && in_shift && (bit_count != '0);
        case (state_q)
            ST_RD_NEXT:                                 rd_cont_d = 1'b1;
            ST_READ_WAIT, ST_READ_LOAD, ST_READ_SHIFT:  rd_cont_d = rd_cont_q;
            default:                                    rd_cont_d = 1'b0;
        endcase
    end

    // State and flag registers; after reset a CS high is required before a new frame.
    always_ff @(posedge s_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rw_q        <= 1'b0;
            rd_cont_q   <= 1'b0;
            armed_q     <= 1'b0;
            frame_err_q <= 1'b0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            rd_cont_q   <= rd_cont_d;
            armed_q     <= armed_d;
            frame_err_q <= frame_err_d;
            lat_q       <= lat_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign ad_we     = (state_q == ST_GOT_ADDR);
    assign sr_we     = (state_q == ST_READ_LOAD);
    assign dm_we     = (state_q == ST_WRITE_COMMIT);
    assign addr_inc  = (state_q == ST_RD_NEXT) || (state_q == ST_WR_NEXT);
    assign frame_err = frame_err_q;
    assign miso_buff = (rw_q == RW_READ) &&
                       ((state_q == ST_READ_SHIFT) || (state_q == ST_RD_NEXT) ||
                        (((state_q == ST_READ_WAIT) || (state_q == ST_READ_LOAD)) && rd_cont_q));

endmodule

// File: tb/tb_spi_slave_fsm_burst.sv
// Directed bench for spi_slave_fsm_burst: three instances (default burst,
// single-word, wide 15/16/3) share stimulus; each test checks one of them.
module tb_spi_slave_fsm_burst;

    localparam logic [31:0] M_MISO = 32'h40;
    localparam logic [31:0] M_AD   = 32'h20;
    localparam logic [31:0] M_SR   = 32'h10;
    localparam logic [31:0] M_DM   = 32'h08;
    localparam logic [31:0] M_INC  = 32'h04;
    localparam logic [31:0] M_FERR = 32'h02;
    localparam logic [31:0] M_BUSY = 32'h01;

    logic s_clk = 1'b0;
    logic reset_n;
    logic cs;
    logic sclk_pos;
    logic read_write;

    wire [6:0] out_a;
    wire [6:0] out_b;
    wire [6:0] out_c;
    wire [31:0] obs_a = {25'd0, out_a};
    wire [31:0] obs_b = {25'd0, out_b};
    wire [31:0] obs_c = {25'd0, out_c};

    int num_checks = 0;
    int num_errors = 0;
    int sel = 0;
    int cnt_sr, cnt_inc, cnt_dm, cnt_ferr, miso_gap;
    bit miso_watch = 1'b0;
    logic [6:0] obs;

    always #5 s_clk = ~s_clk;

    spi_slave_fsm_burst u_dut_a (
        .s_clk(s_clk), .reset_n(reset_n), .CS(cs), .sclk_pos(sclk_pos), .read_write(read_write),
        .miso_buff(out_a[6]), .ad_we(out_a[5]), .sr_we(out_a[4]), .dm_we(out_a[3]),
        .addr_inc(out_a[2]), .frame_err(out_a[1]), .busy(out_a[0])
    );

    spi_slave_fsm_burst #(.ADDR_W(7), .DATA_W(8), .MEM_LAT(1), .BURST_EN(0)) u_dut_b (
        .s_clk(s_clk), .reset_n(reset_n), .CS(cs), .sclk_pos(sclk_pos), .read_write(read_write),
        .miso_buff(out_b[6]), .ad_we(out_b[5]), .sr_we(out_b[4]), .dm_we(out_b[3]),
        .addr_inc(out_b[2]), .frame_err(out_b[1]), .busy(out_b[0])
    );

    spi_slave_fsm_burst #(.ADDR_W(15), .DATA_W(16), .MEM_LAT(3), .BURST_EN(1)) u_dut_c (
        .s_clk(s_clk), .reset_n(reset_n), .CS(cs), .sclk_pos(sclk_pos), .read_write(read_write),
        .miso_buff(out_c[6]), .ad_we(out_c[5]), .sr_we(out_c[4]), .dm_we(out_c[3]),
        .addr_inc(out_c[2]), .frame_err(out_c[1]), .busy(out_c[0])
    );

    always_comb begin
        case (sel)
            0:       obs = out_a;
            1:       obs = out_b;
            default: obs = out_c;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and tally pulses of the watched DUT.
    task automatic step();
        @(posedge s_clk);
        #1;
        if (obs[4]) cnt_sr++;
        if (obs[2]) cnt_inc++;
        if (obs[3]) cnt_dm++;
        if (obs[1]) cnt_ferr++;
        if (miso_watch && !obs[6]) miso_gap++;
    endtask

    task automatic applyStimulus(input logic cs_val);
        cs = cs_val;
        step();
    endtask

    // Shift n bits MSB first; returns right after the edge that consumed the last strobe.
    task automatic send_bits(input int n, input logic [31:0] bits);
        for (int i = 0; i < n; i++) begin
            read_write = bits[n-1-i];
            sclk_pos = 1'b1;
            step();
            sclk_pos = 1'b0;
            if (i != n - 1) step();
        end
    endtask

    task automatic new_test(input int which);
        sel = which;
        cnt_sr = 0; cnt_inc = 0; cnt_dm = 0; cnt_ferr = 0; miso_gap = 0;
        miso_watch = 1'b0;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n = 1'b0; cs = 1'b1; sclk_pos = 1'b0; read_write = 1'b0;
        step();
        step();
        checkOutput("reset_a", obs_a, 32'h0);
        checkOutput("reset_b", obs_b, 32'h0);
        checkOutput("reset_c", obs_c, 32'h0);
        reset_n = 1'b1;
        step();

        // Write frame on the default burst instance.
        new_test(0);
        applyStimulus(1'b0);
        checkOutput("wr_get_addr", obs_a, M_BUSY);
        send_bits(8, {24'd0, 7'h55, 1'b0});
        checkOutput("wr_ad_we", obs_a, M_AD | M_BUSY);
        step();
        checkOutput("wr_shift", obs_a, M_BUSY);
        send_bits(8, 32'hA5);
        checkOutput("wr_dm_we", obs_a, M_DM | M_BUSY);
        step();
        checkOutput("wr_addr_inc", obs_a, M_INC | M_BUSY);
        step();
        applyStimulus(1'b1);
        checkOutput("wr_idle", obs_a, 32'h0);
        checkOutput("wr_inc_count", 32'(cnt_inc), 32'd1);

        // Single-word read on the non-burst instance.
        new_test(1);
        applyStimulus(1'b0);
        send_bits(8, {24'd0, 7'h2A, 1'b1});
        checkOutput("rd_ad_we", obs_b, M_AD | M_BUSY);
        step();
        checkOutput("rd_wait", obs_b, M_BUSY);
        step();
        checkOutput("rd_sr_we", obs_b, M_SR | M_BUSY);
        step();
        checkOutput("rd_shift", obs_b, M_MISO | M_BUSY);
        send_bits(4, 32'h0);
        checkOutput("rd_shift_mid", obs_b, M_MISO | M_BUSY);
        send_bits(4, 32'h0);
        checkOutput("rd_done", obs_b, M_BUSY);
        applyStimulus(1'b1);
        checkOutput("rd_idle", obs_b, 32'h0);

        // Three-word burst read on the default instance.
        new_test(0);
        applyStimulus(1'b0);
        send_bits(8, {24'd0, 7'h10, 1'b1});
        step();
        step();
        step();
        miso_watch = 1'b1;
        for (int w = 0; w < 3; w++) begin
            send_bits(8, 32'h0);
            if (w < 2) begin
                step();
                step();
                step();
            end
        end
        step();
        miso_watch = 1'b0;
        applyStimulus(1'b1);
        checkOutput("burst_sr_count", 32'(cnt_sr), 32'd3);
        checkOutput("burst_inc_count", 32'(cnt_inc), 32'd3);
        checkOutput("burst_miso_gap", 32'(miso_gap), 32'd0);
        checkOutput("burst_idle", obs_a, 32'h0);

        // Chip select rises after 4 of 8 write strobes.
        new_test(0);
        applyStimulus(1'b0);
        send_bits(8, {24'd0, 7'h33, 1'b0});
        step();
        send_bits(4, 32'hF);
        applyStimulus(1'b1);
        checkOutput("ferr_pulse", obs_a, M_FERR);
        step();
        checkOutput("ferr_cleared", obs_a, 32'h0);
        checkOutput("ferr_count", 32'(cnt_ferr), 32'd1);
        checkOutput("ferr_no_dm_we", 32'(cnt_dm), 32'd0);

        // Asynchronous reset in the middle of a read word.
        new_test(0);
        applyStimulus(1'b0);
        send_bits(8, {24'd0, 7'h01, 1'b1});
        step();
        step();
        step();
        send_bits(3, 32'h0);
        checkOutput("rst_pre", obs_a, M_MISO | M_BUSY);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async", obs_a, 32'h0);
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        checkOutput("rst_no_restart", obs_a, 32'h0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("rst_restart", obs_a, M_BUSY);

        // Wide instance write frame.
        new_test(2);
        applyStimulus(1'b0);
        send_bits(15, 32'h1234 >> 1);
        checkOutput("wide_wr_hdr15", obs_c, M_BUSY);
        send_bits(1, 32'h0);
        checkOutput("wide_wr_ad_we", obs_c, M_AD | M_BUSY);
        step();
        send_bits(15, 32'h0);
        checkOutput("wide_wr_data15", obs_c, M_BUSY);
        send_bits(1, 32'h0);
        checkOutput("wide_wr_dm_we", obs_c, M_DM | M_BUSY);
        applyStimulus(1'b1);
        checkOutput("wide_wr_idle", obs_c, 32'h0);

        // Wide instance read frame: three-clock memory latency.
        new_test(2);
        applyStimulus(1'b0);
        send_bits(16, 32'h0ACF);
        checkOutput("wide_rd_ad_we", obs_c, M_AD | M_BUSY);
        step();
        step();
        step();
        checkOutput("wide_rd_wait3", obs_c, M_BUSY);
        step();
        checkOutput("wide_rd_sr_we", obs_c, M_SR | M_BUSY);
        applyStimulus(1'b1);

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
